// File: rtl/icache_ctrl_nway_if.sv
// Fetch/L2/array-side signal bundle for the N-way icache controller.
interface icache_ctrl_nway_if #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned SETS  = 8,
  parameter int unsigned IDX_W = $clog2(SETS)
);
  logic             icache_read;
  logic [IDX_W-1:0] icache_index;
  logic [WAYS-1:0]  hit;
  logic [WAYS-1:0]  valid;
  logic             flush;
  logic             icache_resp;
  logic             L2_read;
  logic             L2_resp;
  logic [WAYS-1:0]  fill_way;
  logic [WAYS-1:0]  valid_write;
  logic             valid_datain;
  logic [IDX_W-1:0] valid_index;
  logic             busy;

  modport master (
    output icache_read, icache_index, hit, valid, flush, L2_resp,
    input  icache_resp, L2_read, fill_way, valid_write, valid_datain, valid_index, busy
  );

  modport slave (
    input  icache_read, icache_index, hit, valid, flush, L2_resp,
    output icache_resp, L2_read, fill_way, valid_write, valid_datain, valid_index, busy
  );
endinterface

// File: rtl/icache_ctrl_nway.sv
// N-way set-associative icache controller with tree PLRU, invalid-first victims and a flush walk.
// Optional perf counters (hit_count/miss_count) enabled by defining ICACHE_PERF_CNT_EN.
module icache_ctrl_nway #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned SETS  = 8,
  parameter int unsigned IDX_W = $clog2(SETS)
) (
  input  logic               clk,
  input  logic               rst,
  icache_ctrl_nway_if.slave  bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);

  localparam int unsigned PLRU_W = WAYS - 1;
  localparam int unsigned LEVELS = $clog2(WAYS);

  typedef enum logic [1:0] {S_HIT, S_MISS, S_FILL, S_FLUSH} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   flush_cnt, flush_cnt_nx;
  logic [IDX_W-1:0]   miss_idx, miss_idx_nx;
  logic [WAYS-1:0]    victim, victim_nx, victim_c;
  logic [PLRU_W-1:0]  plru [SETS];
  logic [PLRU_W-1:0]  plru_row_nx, cur_row;
  logic [IDX_W-1:0]   plru_idx;
  logic               plru_we;
  logic               found;
  int                 node;

  // Lowest set bit wins, which also resolves an illegal multi-hot hit vector.
  function automatic int lowest(input logic [WAYS-1:0] v);
    int r;
    r = 0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) if (v[w]) r = w;
    return r;
  endfunction

  // Point every node on the way's path away from it.
  function automatic logic [PLRU_W-1:0] touch(input logic [PLRU_W-1:0] row, input int way);
    logic [PLRU_W-1:0] r;
    int n, p;
    r = row;
    n = way + int'(PLRU_W);
    for (int l = 0; l < int'(LEVELS); l++) begin
      p = (n - 1) / 2;
      for (int k = 0; k < int'(PLRU_W); k++) if (k == p) r[k] = (n % 2 == 1);
      n = p;
    end
    return r;
  endfunction

  // Victim: first invalid way, else follow the PLRU tree of the requested set.
  always_comb begin
    victim_c = '0;
    found    = 1'b0;
    cur_row  = plru[bus.icache_index];
    node     = 0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (!found && !bus.valid[w]) begin
        victim_c = WAYS'(1) << w;
        found    = 1'b1;
      end
    end
    if (!found) begin
      for (int l = 0; l < int'(LEVELS); l++) begin
        for (int k = 0; k < int'(PLRU_W); k++) begin
          if (k == node) node = 2 * node + 1 + (cur_row[k] ? 1 : 0);
        end
      end
      victim_c = WAYS'(1) << (node - int'(PLRU_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FLUSH;
      flush_cnt <= '0;
      miss_idx  <= '0;
      victim    <= '0;
      for (int s = 0; s < int'(SETS); s++) plru[s] <= '0;
    end else begin
      state     <= state_nx;
      flush_cnt <= flush_cnt_nx;
      miss_idx  <= miss_idx_nx;
      victim    <= victim_nx;
      if (plru_we) plru[plru_idx] <= plru_row_nx;
    end
  end

  always_comb begin
    state_nx         = state;
    flush_cnt_nx     = flush_cnt;
    miss_idx_nx      = miss_idx;
    victim_nx        = victim;
    plru_we          = 1'b0;
    plru_idx         = bus.icache_index;
    plru_row_nx      = '0;
    bus.icache_resp  = 1'b0;
    bus.L2_read      = 1'b0;
    bus.fill_way     = '0;
    bus.valid_write  = '0;
    bus.valid_datain = 1'b0;
    bus.valid_index  = bus.icache_index;
    bus.busy         = 1'b0;
    case (state)
      S_HIT: begin
        if (bus.flush) begin
          state_nx = S_FLUSH;
        end else if (bus.icache_read && (|bus.hit)) begin
          bus.icache_resp = 1'b1;
          plru_we         = 1'b1;
          plru_row_nx     = touch(plru[bus.icache_index], lowest(bus.hit));
        end else if (bus.icache_read) begin
          miss_idx_nx = bus.icache_index;
          victim_nx   = victim_c;
          state_nx    = S_MISS;
        end
      end
      S_MISS: begin
        bus.busy        = 1'b1;
        bus.L2_read     = 1'b1;
        bus.fill_way    = victim;
        bus.valid_index = miss_idx;
        if (bus.L2_resp) state_nx = S_FILL;
      end
      S_FILL: begin
        bus.busy         = 1'b1;
        bus.valid_write  = victim;
        bus.valid_datain = 1'b1;
        bus.valid_index  = miss_idx;
        plru_we          = 1'b1;
        plru_idx         = miss_idx;
        plru_row_nx      = touch(plru[miss_idx], lowest(victim));
        state_nx         = S_HIT;
      end
      S_FLUSH: begin
        bus.busy        = 1'b1;
        bus.valid_write = '1;
        bus.valid_index = flush_cnt;
        plru_we         = 1'b1;
        plru_idx        = flush_cnt;
        if (flush_cnt == IDX_W'(SETS - 1)) begin
          flush_cnt_nx = '0;
          state_nx     = S_HIT;
        end else begin
          flush_cnt_nx = flush_cnt + IDX_W'(1);
        end
      end
      default: state_nx = S_FLUSH;
    endcase
  end

`ifdef ICACHE_PERF_CNT_EN
  logic after_fill;

  // Responses right after FILL are the tail of a miss, not hits.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      after_fill <= 1'b0;
    end else begin
      after_fill <= (state == S_FILL);
      if (bus.icache_resp && !after_fill) hit_count <= hit_count + 32'(1);
      if (state == S_HIT && state_nx == S_MISS) miss_count <= miss_count + 32'(1);
    end
  end
`endif

endmodule

// File: tb/tb_icache_ctrl_nway.sv
// Directed, scoreboarded bench for icache_ctrl_nway (WAYS=4, SETS=8).
module tb_icache_ctrl_nway;
  localparam int unsigned WAYS = 4;
  localparam int unsigned SETS = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_hits = 0;
  int   exp_misses = 0;
  logic [3:0] sb [$];

  always #5 clk = ~clk;

  icache_ctrl_nway_if #(.WAYS(WAYS), .SETS(SETS)) bus ();

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
  icache_ctrl_nway #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hit_count(hit_count), .miss_count(miss_count));
`else
  icache_ctrl_nway #(.WAYS(WAYS), .SETS(SETS)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next active edge.
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  // Entry: first FLUSH cycle. Exit: first HIT cycle.
  task automatic flush_walk(input string tag);
    for (int i = 0; i < int'(SETS); i++) begin
      #1;
      chk({tag, "_vwr"}, 32'(bus.valid_write), 32'hF);
      chk({tag, "_vdin"}, 32'(bus.valid_datain), 32'h0);
      chk({tag, "_vidx"}, 32'(bus.valid_index), 32'(i));
      chk({tag, "_busy"}, 32'(bus.busy), 32'h1);
      chk({tag, "_l2rd"}, 32'(bus.L2_read), 32'h0);
      chk({tag, "_resp"}, 32'(bus.icache_resp), 32'h0);
      nxt();
    end
    #1;
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_idle_vwr"}, 32'(bus.valid_write), 32'h0);
    nxt();
  endtask

  task automatic hit_one(input logic [2:0] idx, input logic [3:0] way, input logic [3:0] vld);
    bus.icache_index = idx;
    bus.valid = vld;
    bus.hit = way;
    bus.icache_read = 1'b1;
    #1;
    chk("hit_resp", 32'(bus.icache_resp), 32'h1);
    chk("hit_busy", 32'(bus.busy), 32'h0);
    exp_hits++;
    nxt();
    bus.icache_read = 1'b0;
    bus.hit = '0;
  endtask

  // Full miss: HIT -> MISS (l2_wait+1 cycles) -> FILL -> HIT with response -> idle.
  task automatic do_miss(input string tag, input logic [2:0] idx, input logic [3:0] vld,
                         input logic [3:0] exp_vict, input int l2_wait, input bit flush_pulse);
    logic [3:0] ev;
    bus.icache_index = idx;
    bus.valid = vld;
    bus.hit = '0;
    bus.icache_read = 1'b1;
    sb.push_back(exp_vict);
    exp_misses++;
    #1;
    chk({tag, "_hit_resp"}, 32'(bus.icache_resp), 32'h0);
    nxt();
    ev = sb.pop_front();
    for (int c = 0; c <= l2_wait; c++) begin
      bus.flush = flush_pulse && (c == 0);
      bus.L2_resp = (c == l2_wait);
      #1;
      chk({tag, "_l2rd"}, 32'(bus.L2_read), 32'h1);
      chk({tag, "_fill_way"}, 32'(bus.fill_way), 32'(ev));
      chk({tag, "_miss_vidx"}, 32'(bus.valid_index), 32'(idx));
      chk({tag, "_miss_busy"}, 32'(bus.busy), 32'h1);
      nxt();
    end
    bus.flush = 1'b0;
    bus.L2_resp = 1'b0;
    #1;
    chk({tag, "_fill_vwr"}, 32'(bus.valid_write), 32'(ev));
    chk({tag, "_fill_vdin"}, 32'(bus.valid_datain), 32'h1);
    chk({tag, "_fill_vidx"}, 32'(bus.valid_index), 32'(idx));
    chk({tag, "_fill_l2rd"}, 32'(bus.L2_read), 32'h0);
    chk({tag, "_fill_resp"}, 32'(bus.icache_resp), 32'h0);
    bus.hit = ev;
    bus.valid = vld | ev;
    nxt();
    #1;
    chk({tag, "_late_resp"}, 32'(bus.icache_resp), 32'h1);
    nxt();
    bus.icache_read = 1'b0;
    bus.hit = '0;
    #1;
    chk({tag, "_after_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_after_vwr"}, 32'(bus.valid_write), 32'h0);
    nxt();
  endtask

  initial begin
    rst = 1'b1;
    bus.icache_read = 1'b0;
    bus.icache_index = '0;
    bus.hit = '0;
    bus.valid = '0;
    bus.flush = 1'b0;
    bus.L2_resp = 1'b0;
    nxt();
    rst = 1'b0;

    // 1: reset flush walk
    flush_walk("rst_flush");

    // 2: cold miss, L2 answers 5 cycles after the request
    do_miss("cold", 3'd3, 4'b0000, 4'b0001, 5, 1'b0);

    // 3: PLRU order, hits 0..3 leave way 0 as victim
    hit_one(3'd2, 4'b0001, 4'hF);
    hit_one(3'd2, 4'b0010, 4'hF);
    hit_one(3'd2, 4'b0100, 4'hF);
    hit_one(3'd2, 4'b1000, 4'hF);
    do_miss("plru_a", 3'd2, 4'hF, 4'b0001, 2, 1'b0);
    hit_one(3'd2, 4'b0001, 4'hF);
    hit_one(3'd2, 4'b0010, 4'hF);
    hit_one(3'd2, 4'b0100, 4'hF);
    hit_one(3'd2, 4'b1000, 4'hF);
    hit_one(3'd2, 4'b0001, 4'hF);
    do_miss("plru_b", 3'd2, 4'hF, 4'b0100, 1, 1'b0);

    // 4: invalid-first overrides PLRU
    hit_one(3'd5, 4'b0001, 4'b1011);
    hit_one(3'd5, 4'b0010, 4'b1011);
    hit_one(3'd5, 4'b1000, 4'b1011);
    do_miss("inv_first", 3'd5, 4'b1011, 4'b0100, 1, 1'b0);
    do_miss("inv_low", 3'd6, 4'b1001, 4'b0010, 0, 1'b0);

`ifdef ICACHE_PERF_CNT_EN
    #1;
    chk("perf_hits", hit_count, 32'(exp_hits));
    chk("perf_misses", miss_count, 32'(exp_misses));
    nxt();
`endif

    // 5: flush beats a same-cycle hitting read
    bus.icache_index = 3'd3;
    bus.valid = 4'hF;
    bus.hit = 4'b0001;
    bus.icache_read = 1'b1;
    bus.flush = 1'b1;
    #1;
    chk("flush_prio_resp", 32'(bus.icache_resp), 32'h0);
    nxt();
    bus.flush = 1'b0;
    bus.hit = '0;
    bus.valid = '0;
    flush_walk("flush_req");
    do_miss("post_flush", 3'd3, 4'b0000, 4'b0001, 1, 1'b0);
    do_miss("flush_in_miss", 3'd4, 4'b0001, 4'b0010, 2, 1'b1);

    // 6: reset in the middle of a miss
    bus.icache_index = 3'd7;
    bus.valid = 4'hF;
    bus.hit = '0;
    bus.icache_read = 1'b1;
    nxt();
    #1;
    chk("rmiss_l2rd", 32'(bus.L2_read), 32'h1);
    nxt();
    rst = 1'b1;
    bus.icache_read = 1'b0;
    nxt();
    rst = 1'b0;
    flush_walk("rst_mid_miss");
`ifdef ICACHE_PERF_CNT_EN
    #1;
    chk("perf_rst_hits", hit_count, 32'h0);
    chk("perf_rst_misses", miss_count, 32'h0);
    nxt();
`endif
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
